asic_iobank: RTL and testbench



---
 rtl/asic_iobank.sv | 83 ++++++++
 tb/tb_asic_iobank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/asic_iobank.sv
// asic_iobank: N-channel soft GPIO bank with registered drive, input synchronizer, glitch filter and sticky edge interrupts
module asic_iobank #(
  parameter int N    = 8,
  parameter     TYPE = "SOFT",
  parameter int SYNC = 2,
  parameter int DBW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  inout  wire  [N-1:0]   pad,
  inout  wire            vddio,
  inout  wire            vssio,
  inout  wire            vdd,
  inout  wire            vss,
  inout  wire            poc,
  input  logic [N-1:0]   dout,
  input  logic [N-1:0]   oen,
  input  logic [N-1:0]   ie,
  input  logic [N-1:0]   filt_en,
  input  logic [DBW-1:0] dbcnt,
  input  logic [N-1:0]   rise_en,
  input  logic [N-1:0]   fall_en,
  input  logic [N-1:0]   irq_clr,
  output logic [N-1:0]   din,
  output logic [N-1:0]   irq_status,
  output logic           irq
);
  logic w_unused;
  assign w_unused = &{1'b0, vddio, vssio, vdd, vss, poc};
  if (TYPE == "SOFT") begin : g_soft
    logic [N-1:0]           r_dout, r_oen, r_ie, r_din, r_din_d, r_stat;
    logic [SYNC-1:0][N-1:0] r_sync;
    logic [N-1:0][DBW-1:0]  r_cnt;
    logic [N-1:0]           w_raw, w_s;
    assign w_raw      = pad & r_ie;
    assign w_s        = r_sync[SYNC-1];
    assign din        = r_din;
    assign irq_status = r_stat;
    assign irq        = |r_stat;
    for (genvar i = 0; i < N; i++) begin : g_pad
      assign pad[i] = r_oen[i] ? 1'bz : r_dout[i];
    end
    // Pad control registers and input synchronizer chain; reset leaves every pad released
    always_ff @(posedge clk)
      if (rst) begin
        r_dout <= '0;
        r_oen  <= '1;
        r_ie   <= '0;
        r_sync <= '0;
      end else begin
        r_dout <= dout;
        r_oen  <= oen;
        r_ie   <= ie;
        r_sync <= {r_sync[SYNC-2:0], w_raw};
      end
    // Glitch filter: din follows s only after dbcnt+1 consecutive differing samples; >= keeps a lowered threshold from stalling
    always_ff @(posedge clk)
      if (rst) begin
        r_din <= '0;
        r_cnt <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          r_din[i] <= (!filt_en[i] || (w_s[i] != r_din[i] && r_cnt[i] >= dbcnt)) ? w_s[i] : r_din[i];
          r_cnt[i] <= (filt_en[i] && w_s[i] != r_din[i] && r_cnt[i] < dbcnt) ? r_cnt[i] + 1'b1 : '0;
        end
      end
    // Edge detection into sticky status; a new event overrides a simultaneous clear
    always_ff @(posedge clk)
      if (rst) begin
        r_din_d <= '0;
        r_stat  <= '0;
      end else begin
        r_din_d <= r_din;
        r_stat  <= (r_stat & ~irq_clr) | (r_din & ~r_din_d & rise_en) | (~r_din & r_din_d & fall_en);
      end
  end else begin : g_hard
    logic w_unused_in;
    assign w_unused_in = &{1'b0, clk, rst, pad, dout, oen, ie, filt_en, dbcnt, rise_en, fall_en, irq_clr};
    assign din        = '0;
    assign irq_status = '0;
    assign irq        = 1'b0;
  end
endmodule

// File: tb/tb_asic_iobank.sv
// tb_asic_iobank: directed and randomized checks of asic_iobank against a history-based reference model
module tb_asic_iobank;
  localparam int N = 8, SYNC = 2, DBW = 4;
  logic clk, rst;
  logic [N-1:0] dout, oen, ie, filt_en, rise_en, fall_en, irq_clr, din, irq_status;
  logic [DBW-1:0] dbcnt;
  logic irq;
  logic [N-1:0] tb_en, tb_val;
  wire  [N-1:0] pad;
  wire vddio, vssio, vdd, vss, poc;
  int total = 0, bad = 0;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign pad[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  asic_iobank #(.N(N), .TYPE("SOFT"), .SYNC(SYNC), .DBW(DBW)) dut (
    .clk(clk), .rst(rst), .pad(pad), .vddio(vddio), .vssio(vssio), .vdd(vdd), .vss(vss), .poc(poc),
    .dout(dout), .oen(oen), .ie(ie), .filt_en(filt_en), .dbcnt(dbcnt), .rise_en(rise_en),
    .fall_en(fall_en), .irq_clr(irq_clr), .din(din), .irq_status(irq_status), .irq(irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: pad samples kept as history; din flips once the trailing run of samples
  // disagreeing with it is longer than the threshold
  logic [N-1:0] m_dout, m_oen, m_ie, m_din, m_dind, m_stat;
  logic [N-1:0] raw_q[$];
  logic [N-1:0] s_q[$];

  task automatic model_edge();
    logic [N-1:0] raw, s, nd;
    int run;
    if (rst) begin
      m_dout = '0; m_oen = '1; m_ie = '0; m_din = '0; m_dind = '0; m_stat = '0;
      raw_q = {}; s_q = {};
      return;
    end
    raw = ((m_oen & tb_val) | (~m_oen & m_dout)) & m_ie;
    s = (raw_q.size() >= SYNC) ? raw_q[raw_q.size() - SYNC] : '0;
    raw_q.push_back(raw);
    if (raw_q.size() > 16) void'(raw_q.pop_front());
    s_q.push_back(s);
    if (s_q.size() > 32) void'(s_q.pop_front());
    for (int c = 0; c < N; c++) begin
      run = 0;
      for (int k = s_q.size() - 1; k >= 0 && s_q[k][c] != m_din[c]; k--) run++;
      nd[c] = (!filt_en[c] || run > int'(dbcnt)) ? s[c] : m_din[c];
    end
    m_stat = (m_stat & ~irq_clr) | (m_din & ~m_dind & rise_en) | (~m_din & m_dind & fall_en);
    m_dind = m_din;
    m_din  = nd;
    m_dout = dout; m_oen = oen; m_ie = ie;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 tb_en = m_oen;
    #1;
    chk("din", din, m_din);
    chk("irq_status", irq_status, m_stat);
    chk("irq", irq, |m_stat);
    chk("pad", pad, (m_oen & tb_val) | (~m_oen & m_dout));
  endtask

  initial begin
    bit hit;
    logic [N-1:0] flip;
    rst = 1; tb_en = '1; tb_val = '0; dout = '0; oen = '1; ie = '0; filt_en = '0; dbcnt = '0;
    rise_en = '0; fall_en = '0; irq_clr = '0;
    step(); step();
    chk("rst_din", din, 0); chk("rst_stat", irq_status, 0); chk("rst_irq", irq, 0);
    rst = 0;
    // Output path
    oen = 8'h00; dout = 8'hA5;
    step();
    chk("drive_a5", pad, 8'hA5);
    oen = 8'h01;
    step();
    chk("release_pad0", pad, 8'hA4);
    // Bypass input latency and rise enable
    oen = '1; tb_val = '0; ie = '1; filt_en = '0; irq_clr = '1; rise_en = 8'hFD;
    repeat (5) step();
    irq_clr = '0;
    step();
    tb_val = 8'h03;
    step(); step();
    chk("byp_e2", din, 8'h00);
    step();
    chk("byp_e3", din, 8'h03);
    step();
    chk("rise_set", irq_status[0], 1'b1);
    chk("rise_masked", irq_status[1], 1'b0);
    // Glitch filter threshold 3
    rise_en = '1; filt_en = '1; dbcnt = 4'd3; irq_clr = '1;
    step();
    irq_clr = '0;
    tb_val[2] = 1'b1;
    repeat (3) step();
    tb_val[2] = 1'b0;
    repeat (6) step();
    chk("glitch3", din[2], 1'b0);
    tb_val[2] = 1'b1;
    repeat (4) step();
    tb_val[2] = 1'b0;
    step();
    chk("pulse4_e5", din[2], 1'b0);
    step();
    chk("pulse4_e6", din[2], 1'b1);
    // Set beats clear on the same edge
    fall_en = 8'h04;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      irq_clr = (m_din[2] == 1'b0 && m_dind[2] == 1'b1) ? 8'h04 : 8'h00;
      hit = irq_clr[2];
      step();
    end
    chk("fall_seen", hit, 1);
    chk("set_wins", irq_status[2], 1'b1);
    irq_clr = '1;
    step();
    irq_clr = '0;
    chk("clr_stat", irq_status, 0);
    chk("clr_irq", irq, 0);
    // Reset in the middle of a filter count
    oen = 8'hF0; tb_val = 8'h0B;
    repeat (4) step();
    rst = 1;
    step();
    chk("midrst_din", din, 0); chk("midrst_stat", irq_status, 0); chk("midrst_irq", irq, 0);
    chk("midrst_pad", pad, tb_val);
    rst = 0;
    repeat (8) step();
    // Input disabled
    oen = '1; filt_en = '0; ie = '0; irq_clr = '1;
    repeat (6) begin tb_val = 8'($urandom); step(); end
    irq_clr = '0;
    repeat (16) begin
      tb_val = 8'($urandom);
      step();
      chk("ie0_din", din, 0); chk("ie0_stat", irq_status, 0);
    end
    // Randomized segments
    for (int seg = 0; seg < 12; seg++) begin
      filt_en = 8'($urandom); dbcnt = 4'($urandom_range(0, 5)); oen = 8'($urandom);
      ie = 8'($urandom) | 8'($urandom); rise_en = 8'($urandom); fall_en = 8'($urandom);
      for (int c = 0; c < 40; c++) begin
        dout = 8'($urandom);
        for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 5) == 0);
        tb_val = tb_val ^ flip;
        irq_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        rst = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
